// File: rtl/float_rec_arbiter.sv
// Round-robin scheduler sharing one external floatRec unit between NREQ requesters.
// A tag pipeline tracks each issued operand and routes rec_y into the requester's result slot.
module float_rec_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NREQ       = 4,
   parameter int unsigned REC_LAT    = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NREQ-1:0]                req_valid,
   input  logic [NREQ*DATA_WIDTH-1:0]     req_data,
   output logic [NREQ-1:0]                req_ready,
   output logic [NREQ-1:0]                rsp_valid,
   output logic [NREQ*DATA_WIDTH-1:0]     rsp_data,
   input  logic [NREQ-1:0]                rsp_ready,
   output logic [DATA_WIDTH-1:0]          rec_x,
   input  logic [DATA_WIDTH-1:0]          rec_y,
   output logic [$clog2(REC_LAT+1)-1:0]   in_flight
);

   localparam int unsigned TW   = $clog2(NREQ);
   localparam int unsigned IFW  = $clog2(REC_LAT + 1);
   localparam int unsigned LAST = REC_LAT - 1;

   logic [REC_LAT-1:0] tag_v;
   logic [TW-1:0]      tag_id [REC_LAT];
   logic [TW-1:0]      rr_ptr;

   logic [NREQ-1:0]    pend_c;
   logic [NREQ-1:0]    elig_c;
   logic [NREQ-1:0]    grant_c;
   logic [TW-1:0]      gidx_c;
   logic               xfer_c;
   logic [TW-1:0]      nxt_ptr_c;

   // A requester is busy while its tag is in flight or its result is still held
   always_comb begin
      pend_c = rsp_valid;
      for (int unsigned s = 0; s < REC_LAT; s++) begin
         if (tag_v[s]) pend_c[tag_id[s]] = 1'b1;
      end
   end

   assign elig_c = req_valid & ~pend_c;

   // First eligible index at or above rr_ptr, wrapping modulo NREQ
   always_comb begin : p_grant
      int unsigned idx;
      idx     = 0;
      xfer_c  = 1'b0;
      gidx_c  = '0;
      grant_c = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = k + 32'(rr_ptr);
         if (idx >= NREQ) idx = idx - NREQ;
         if (!xfer_c && elig_c[TW'(idx)]) begin
            xfer_c = 1'b1;
            gidx_c = TW'(idx);
         end
      end
      if (xfer_c) grant_c[gidx_c] = 1'b1;
   end

   assign req_ready = grant_c;
   assign nxt_ptr_c = (gidx_c == TW'(NREQ - 1)) ? '0 : gidx_c + TW'(1);

   // Operand register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_x  <= '0;
         rr_ptr <= '0;
      end else if (xfer_c) begin
         rec_x  <= req_data[32'(gidx_c)*DATA_WIDTH +: DATA_WIDTH];
         rr_ptr <= nxt_ptr_c;
      end
   end

   // Tag shift register, advances every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int unsigned s = 0; s < REC_LAT; s++) tag_id[s] <= '0;
      end else begin
         tag_v[0]  <= xfer_c;
         tag_id[0] <= gidx_c;
         for (int unsigned s = 1; s < REC_LAT; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   // Occupancy counter tracks the number of valid tag stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= '0;
      end else if (xfer_c && !tag_v[LAST]) begin
         in_flight <= in_flight + IFW'(1);
      end else if (!xfer_c && tag_v[LAST]) begin
         in_flight <= in_flight - IFW'(1);
      end
   end

   // Result slots: capture from the last tag stage, release on rsp_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (rsp_ready[i]) rsp_valid[i] <= 1'b0;
            if (tag_v[LAST] && (tag_id[LAST] == TW'(i))) begin
               rsp_valid[i]                          <= 1'b1;
               rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= rec_y;
            end
         end
      end
   end

endmodule
